// File: rtl/uart_pkg.sv
// Shared types and legal parameter ranges for the UART blocks.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10
   } parity_mode_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      STOP2,
      BREAK
   } rx_state_t;

   localparam int OS_MIN = 8;
   localparam int OS_MAX = 16;
   localparam int DW_MIN = 8;
   localparam int DW_MAX = 32;

   // The reserved encoding 2'b11 behaves like "no parity".
   function automatic parity_mode_t decode_parity(input logic [1:0] mode);
      case (mode)
         2'b01:   return PAR_EVEN;
         2'b10:   return PAR_ODD;
         default: return PAR_NONE;
      endcase
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick generator: one tick every i_div+1 clocks, restartable so the
// first tick lands a fixed distance after the restart is released.
module uart_baud_tick #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_restart,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_tick
);

   logic [DIV_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_restart || (r_cnt == '0)) begin
         r_cnt <= i_div;
      end else begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_tick = !i_restart && (r_cnt == '0);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with parity, one/two stop bits, break handling
// and a valid/ready output register that reports overruns.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge
// START  | half a bit in, confirming the start bit
// DATA   | shifting in payload bits LSB first
// PARITY | checking a parity bit (per byte or per word)
// STOP   | first stop bit
// STOP2  | second stop bit
// BREAK  | line stuck low after a bad stop bit, waiting for it to rise
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = 16,
   parameter int DIV_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx_in,
   input  logic [DIV_W-1:0]      baud_div,
   input  logic [1:0]            parity_mode,
   input  logic                  parity_per_byte,
   input  logic                  two_stop,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  parity_err,
   output logic                  frame_err,
   output logic                  overrun_err,
   output logic                  busy
);

   localparam int SMP_W = $clog2(OVERSAMPLE);
   localparam int BIT_W = $clog2(DATA_WIDTH + 1);

   if (((DATA_WIDTH % 8) != 0) || (DATA_WIDTH < DW_MIN) || (DATA_WIDTH > DW_MAX)) begin : g_bad_dw
      $error("uart_rx_os: DATA_WIDTH must be a multiple of 8 within 8..32");
   end
   if (((OVERSAMPLE % 2) != 0) || (OVERSAMPLE < OS_MIN) || (OVERSAMPLE > OS_MAX)) begin : g_bad_os
      $error("uart_rx_os: OVERSAMPLE must be even within 8..16");
   end

   logic [1:0]            r_sync;
   rx_state_t             r_state, w_state_nxt;
   logic [DIV_W-1:0]      r_div;
   parity_mode_t          r_pmode;
   logic                  r_ppb, r_two;
   logic [SMP_W-1:0]      r_smp;
   logic [BIT_W-1:0]      r_bit_cnt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_par_acc, r_perr, r_ferr;
   logic                  r_m_valid, r_perr_out, r_ferr_out, r_ovr;
   logic [DATA_WIDTH-1:0] r_m_data;
   logic                  w_rxs, w_tick, w_samp, w_done, w_accept, w_par_en;
   logic                  w_last_bit, w_all_bits;
   logic [DIV_W-1:0]      w_div;

   assign w_rxs      = r_sync[1];
   assign w_div      = (r_state == IDLE) ? baud_div : r_div;
   assign w_samp     = w_tick && (r_smp == '0);
   assign w_par_en   = (r_pmode != PAR_NONE);
   assign w_last_bit = (r_bit_cnt == BIT_W'(DATA_WIDTH - 1));
   assign w_all_bits = (r_bit_cnt == BIT_W'(DATA_WIDTH));
   assign w_accept   = r_m_valid && m_ready;

   uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_restart (r_state == IDLE),
      .i_div     (w_div),
      .o_tick    (w_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync  <= 2'b11;
         r_state <= IDLE;
      end else begin
         r_sync  <= {r_sync[0], rx_in};
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      case (r_state)
         IDLE:   if (!w_rxs) w_state_nxt = START;
         START:  if (w_samp) w_state_nxt = w_rxs ? IDLE : DATA;
         DATA: begin
            if (w_samp) begin
               if (w_par_en && (w_last_bit || (r_ppb && (r_bit_cnt[2:0] == 3'd7))))
                  w_state_nxt = PARITY;
               else if (w_last_bit)
                  w_state_nxt = STOP;
            end
         end
         PARITY: if (w_samp) w_state_nxt = w_all_bits ? STOP : DATA;
         STOP: begin
            if (w_samp) begin
               if (r_two) begin
                  w_state_nxt = STOP2;
               end else begin
                  w_done      = 1'b1;
                  w_state_nxt = w_rxs ? IDLE : BREAK;
               end
            end
         end
         STOP2: begin
            if (w_samp) begin
               w_done      = 1'b1;
               w_state_nxt = w_rxs ? IDLE : BREAK;
            end
         end
         BREAK:   if (w_rxs) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div     <= '0;
         r_pmode   <= PAR_NONE;
         r_ppb     <= 1'b0;
         r_two     <= 1'b0;
         r_smp     <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_par_acc <= 1'b0;
         r_perr    <= 1'b0;
         r_ferr    <= 1'b0;
      end else begin
         if (r_state == IDLE) begin
            r_smp     <= SMP_W'(OVERSAMPLE / 2 - 1);
            r_bit_cnt <= '0;
            r_par_acc <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            if (!w_rxs) begin
               r_div   <= baud_div;
               r_pmode <= decode_parity(parity_mode);
               r_ppb   <= parity_per_byte;
               r_two   <= two_stop;
            end
         end else if (w_tick) begin
            r_smp <= (r_smp == '0) ? SMP_W'(OVERSAMPLE - 1) : r_smp - 1'b1;
         end
         if (w_samp) begin
            case (r_state)
               DATA: begin
                  r_shift   <= {w_rxs, r_shift[DATA_WIDTH-1:1]};
                  r_par_acc <= r_par_acc ^ w_rxs;
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
               PARITY: begin
                  // odd parity expects the complement of the data XOR
                  if (w_rxs != (r_par_acc ^ (r_pmode == PAR_ODD))) r_perr <= 1'b1;
                  r_par_acc <= 1'b0;
               end
               STOP, STOP2: if (!w_rxs) r_ferr <= 1'b1;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m_valid  <= 1'b0;
         r_m_data   <= '0;
         r_perr_out <= 1'b0;
         r_ferr_out <= 1'b0;
         r_ovr      <= 1'b0;
      end else if (w_done && (!r_m_valid || w_accept)) begin
         r_m_valid  <= 1'b1;
         r_m_data   <= r_shift;
         r_perr_out <= r_perr;
         r_ferr_out <= r_ferr || !w_rxs;
         r_ovr      <= 1'b0;
      end else if (w_done) begin
         r_ovr <= 1'b1;
      end else if (w_accept) begin
         r_m_valid <= 1'b0;
         r_ovr     <= 1'b0;
      end
   end

   assign m_valid     = r_m_valid;
   assign m_data      = r_m_data;
   assign parity_err  = r_perr_out;
   assign frame_err   = r_ferr_out;
   assign overrun_err = r_ovr;
   assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8-bit and a 16-bit receiver driven with serial
// frames built from the protocol rules, checked against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_os;

   localparam int OS = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        rxl[2];
   logic [15:0] bdiv[2];
   logic [1:0]  pm[2];
   logic        ppb[2], two[2], rdy[2];
   logic        mval[2], perr[2], ferr[2], ovr[2], bsy[2];
   logic [7:0]  d8;
   logic [15:0] d16;
   logic [31:0] mdat[2];

   assign mdat[0] = {24'd0, d8};
   assign mdat[1] = {16'd0, d16};

   uart_rx_os #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .DIV_W(16)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .rx_in(rxl[0]), .baud_div(bdiv[0]),
      .parity_mode(pm[0]), .parity_per_byte(ppb[0]), .two_stop(two[0]),
      .m_valid(mval[0]), .m_ready(rdy[0]), .m_data(d8), .parity_err(perr[0]),
      .frame_err(ferr[0]), .overrun_err(ovr[0]), .busy(bsy[0])
   );

   uart_rx_os #(.DATA_WIDTH(16), .OVERSAMPLE(OS), .DIV_W(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .rx_in(rxl[1]), .baud_div(bdiv[1]),
      .parity_mode(pm[1]), .parity_per_byte(ppb[1]), .two_stop(two[1]),
      .m_valid(mval[1]), .m_ready(rdy[1]), .m_data(d16), .parity_err(perr[1]),
      .frame_err(ferr[1]), .overrun_err(ovr[1]), .busy(bsy[1])
   );

   // frame-level model of each receiver's output register
   bit          mv[2], mpe[2], mfe[2], mov[2];
   logic [31:0] md[2];
   bit          in_frame[2];
   bit          chk_on;
   int          n_pass, n_total;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         mv[d] = 0; mpe[d] = 0; mfe[d] = 0; mov[d] = 0; md[d] = '0;
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && chk_on) begin
         for (int d = 0; d < 2; d++) begin
            if (!in_frame[d]) begin
               chk($sformatf("dut%0d.valid", d), mval[d], mv[d]);
               chk($sformatf("dut%0d.busy", d), bsy[d], 0);
               chk($sformatf("dut%0d.overrun", d), ovr[d], mov[d]);
               if (mv[d]) begin
                  chk($sformatf("dut%0d.data", d), mdat[d], md[d]);
                  chk($sformatf("dut%0d.parity_err", d), perr[d], mpe[d]);
                  chk($sformatf("dut%0d.frame_err", d), ferr[d], mfe[d]);
               end
            end
         end
      end
   end

   // Drives one complete frame on receiver d. stops[0]/stops[1] are the stop
   // bit levels, pflip[j] inverts the j-th parity bit, hold extends a low line.
   task automatic send_frame(input int d, input logic [31:0] data, input int div,
                             input logic [1:0] pmode, input bit pb, input bit ts,
                             input logic [3:0] pflip, input logic [1:0] stops,
                             input bit scramble, input int hold);
      int          dw, cyc, j;
      bit          q[$];
      bit          pen, pe_exp, fe_exp, pbit;
      logic [31:0] word, covered;
      dw   = (d == 0) ? 8 : 16;
      word = data & ((32'd1 << dw) - 32'd1);
      pen  = (pmode == 2'b01) || (pmode == 2'b10);
      in_frame[d] = 1;
      bdiv[d] = 16'(div); pm[d] = pmode; ppb[d] = pb; two[d] = ts;
      cyc = OS * (div + 1);
      pe_exp = 0;
      q.push_back(1'b0);
      for (int i = 0; i < dw; i++) begin
         q.push_back(word[i]);
         if (pen && ((pb && (i % 8 == 7)) || (!pb && (i == dw - 1)))) begin
            j       = pb ? i / 8 : 0;
            covered = pb ? ((word >> (8 * j)) & 32'hFF) : word;
            pbit    = ^covered;
            if (pmode == 2'b10) pbit = !pbit;
            pbit    = pbit ^ pflip[j];
            pe_exp  = pe_exp | pflip[j];
            q.push_back(pbit);
         end
      end
      q.push_back(stops[0]);
      if (ts) q.push_back(stops[1]);
      fe_exp = !stops[0] || (ts && !stops[1]);
      for (int k = 0; k < q.size(); k++) begin
         rxl[d] = q[k];
         if (k == 0 && scramble) begin
            wait_clk(6);
            bdiv[d] = 16'($urandom); pm[d] = ~pmode; ppb[d] = !pb; two[d] = !ts;
            wait_clk(cyc - 6);
         end else begin
            wait_clk(cyc);
         end
      end
      if (hold > 0) begin
         wait_clk(hold);
         chk("break.busy_while_low", bsy[d], 1);
      end
      rxl[d] = 1'b1;
      wait_clk(6);
      bdiv[d] = 16'(div); pm[d] = pmode; ppb[d] = pb; two[d] = ts;
      if (!mv[d]) begin
         mv[d] = 1; md[d] = word; mpe[d] = pe_exp; mfe[d] = fe_exp;
      end else begin
         mov[d] = 1;
      end
      in_frame[d] = 0;
   endtask

   task automatic ack(input int d);
      rdy[d] = 1'b1;
      wait_clk(1);
      rdy[d] = 1'b0;
      if (mv[d]) begin
         mv[d] = 0; mov[d] = 0;
      end
   endtask

   initial begin
      rst_n = 1'b0; chk_on = 0; n_pass = 0; n_total = 0;
      for (int d = 0; d < 2; d++) begin
         rxl[d] = 1'b1; bdiv[d] = '0; pm[d] = '0; ppb[d] = 0; two[d] = 0; rdy[d] = 0;
         in_frame[d] = 0;
      end
      model_reset();
      wait_clk(3);
      for (int d = 0; d < 2; d++) begin
         chk("reset.valid", mval[d], 0);
         chk("reset.data", mdat[d], 0);
         chk("reset.flags", {perr[d], ferr[d], ovr[d]}, 0);
         chk("reset.busy", bsy[d], 0);
      end
      rst_n = 1'b1;
      wait_clk(2);
      chk_on = 1;

      // 0xA5, even parity, held until accepted
      send_frame(0, 32'hA5, 0, 2'b01, 0, 0, 4'b0, 2'b11, 0, 0);
      chk("t1.data", mdat[0], 32'hA5);
      chk("t1.flags", {perr[0], ferr[0], ovr[0]}, 0);
      wait_clk(40);
      chk("t1.held", mval[0], 1);
      ack(0);
      chk("t1.acked", mval[0], 0);

      // 16-bit, per-byte odd parity, upper byte's parity inverted
      send_frame(1, 32'h3C01, 1, 2'b10, 1, 0, 4'b0010, 2'b11, 1, 0);
      chk("t2.data", mdat[1], 32'h3C01);
      chk("t2.parity_err", perr[1], 1);
      chk("t2.frame_err", ferr[1], 0);
      ack(1);

      // 4-clock glitch is rejected as a false start
      in_frame[0] = 1; bdiv[0] = '0;
      rxl[0] = 1'b0;
      wait_clk(4);
      chk("t3.busy_rise", bsy[0], 1);
      rxl[0] = 1'b1;
      wait_clk(30);
      chk("t3.busy_fall", bsy[0], 0);
      chk("t3.no_valid", mval[0], 0);
      in_frame[0] = 0;

      // bad second stop bit, line held low for three bit times
      send_frame(0, 32'h96, 0, 2'b00, 0, 1, 4'b0, 2'b01, 0, 2 * OS);
      chk("t4.data", mdat[0], 32'h96);
      chk("t4.frame_err", ferr[0], 1);
      chk("t4.overrun", ovr[0], 0);
      ack(0);

      // back-to-back frames without ready
      send_frame(0, 32'h11, 0, 2'b00, 0, 0, 4'b0, 2'b11, 0, 0);
      send_frame(0, 32'h22, 0, 2'b00, 0, 0, 4'b0, 2'b11, 0, 0);
      chk("t5.data", mdat[0], 32'h11);
      chk("t5.overrun", ovr[0], 1);
      ack(0);
      chk("t5.valid_clr", mval[0], 0);
      chk("t5.overrun_clr", ovr[0], 0);

      // reset in the middle of DATA
      send_frame(0, 32'h77, 1, 2'b00, 0, 0, 4'b0, 2'b11, 0, 0);
      in_frame[0] = 1; bdiv[0] = '0;
      rxl[0] = 1'b0;
      wait_clk(OS + 3 * OS + 8);
      chk("t6.mid_busy", bsy[0], 1);
      rst_n = 1'b0;
      wait_clk(1);
      chk("t6.valid", mval[0], 0);
      chk("t6.data", mdat[0], 0);
      chk("t6.flags", {perr[0], ferr[0], ovr[0]}, 0);
      chk("t6.busy", bsy[0], 0);
      model_reset();
      rxl[0] = 1'b1;
      wait_clk(2);
      rst_n = 1'b1;
      wait_clk(3);
      in_frame[0] = 0;
      send_frame(0, 32'h5A, 0, 2'b01, 0, 0, 4'b0, 2'b11, 0, 0);
      chk("t6.after_data", mdat[0], 32'h5A);
      ack(0);

      // randomized frames
      for (int n = 0; n < 30; n++) begin
         int          d, div;
         logic [1:0]  pmode, stops;
         logic [3:0]  pflip;
         d     = int'($urandom_range(0, 1));
         div   = int'($urandom_range(0, 2));
         pmode = 2'($urandom_range(0, 3));
         pflip = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0;
         stops[0] = ($urandom_range(0, 9) != 0);
         stops[1] = ($urandom_range(0, 9) != 0);
         send_frame(d, $urandom, div, pmode, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), pflip, stops, 1'($urandom_range(0, 1)), 0);
         wait_clk(int'($urandom_range(1, 20)));
         if ($urandom_range(0, 2) != 0) ack(d);
         wait_clk(int'($urandom_range(1, 10)));
      end
      ack(0);
      ack(1);
      wait_clk(5);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
